// File: rtl/keypad_time_entry_pkg.sv
// ============================================================================
// keypad_time_entry_pkg : keypad scan codes, FSM states and time range helper
// Revision 1.0 : initial release
// ============================================================================
`default_nettype none

package keypad_time_entry_pkg;

  // PS/2 set-2 keypad make codes
  localparam logic [7:0] KP_0            = 8'h70;
  localparam logic [7:0] KP_1            = 8'h69;
  localparam logic [7:0] KP_2            = 8'h72;
  localparam logic [7:0] KP_3            = 8'h7A;
  localparam logic [7:0] KP_4            = 8'h6B;
  localparam logic [7:0] KP_5            = 8'h73;
  localparam logic [7:0] KP_6            = 8'h74;
  localparam logic [7:0] KP_7            = 8'h6C;
  localparam logic [7:0] KP_8            = 8'h75;
  localparam logic [7:0] KP_9            = 8'h7D;
  localparam logic [7:0] KP_MINUS        = 8'h7B;
  localparam logic [7:0] KP_STAR         = 8'h7C;
  localparam logic [7:0] KP_KEY_RELEASED = 8'hF0;
  localparam logic [7:0] KP_INVALID      = 8'h00;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    MAKE   = 2'd1,
    BREAK  = 2'd2,
    ACCEPT = 2'd3
  } kp_state_e;

  // {H1,H0,M1,M0} must describe a wall-clock time 00:00..23:59
  function automatic logic time_in_range(input logic [15:0] t);
    return (t[15:12] <= 4'd2) &&
           ((t[15:12] != 4'd2) || (t[11:8] <= 4'd3)) &&
           (t[11:8] <= 4'd9) &&
           (t[7:4] <= 4'd5) &&
           (t[3:0] <= 4'd9);
  endfunction

endpackage

`default_nettype wire

// File: rtl/keypad_time_entry_kp_decode.sv
// ============================================================================
// kp_decode : combinational keypad scan code classifier
// Revision 1.0 : initial release
// ============================================================================
`default_nettype none

module kp_decode
  import keypad_time_entry_pkg::*;
(
  input  logic [7:0] code_i,
  output logic       is_digit_o,
  output logic [3:0] digit_o,
  output logic       is_minus_o,
  output logic       is_star_o,
  output logic       is_release_o
);

  always_comb begin
    is_digit_o   = 1'b0;
    digit_o      = 4'd0;
    is_minus_o   = 1'b0;
    is_star_o    = 1'b0;
    is_release_o = 1'b0;
    case (code_i)
      KP_0: begin is_digit_o = 1'b1; digit_o = 4'd0; end
      KP_1: begin is_digit_o = 1'b1; digit_o = 4'd1; end
      KP_2: begin is_digit_o = 1'b1; digit_o = 4'd2; end
      KP_3: begin is_digit_o = 1'b1; digit_o = 4'd3; end
      KP_4: begin is_digit_o = 1'b1; digit_o = 4'd4; end
      KP_5: begin is_digit_o = 1'b1; digit_o = 4'd5; end
      KP_6: begin is_digit_o = 1'b1; digit_o = 4'd6; end
      KP_7: begin is_digit_o = 1'b1; digit_o = 4'd7; end
      KP_8: begin is_digit_o = 1'b1; digit_o = 4'd8; end
      KP_9: begin is_digit_o = 1'b1; digit_o = 4'd9; end
      KP_MINUS:        is_minus_o   = 1'b1;
      KP_STAR:         is_star_o    = 1'b1;
      KP_KEY_RELEASED: is_release_o = 1'b1;
      default: ;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/keypad_time_entry.sv
// ============================================================================
// keypad_time_entry : PS/2 keypad make/break sequencer -> BCD time load strobes
// Revision 1.0 : initial release; optional macro KEYPAD_TIME_ENTRY_RANGE_CHECK_EN
// ============================================================================
`default_nettype none

module keypad_time_entry
  import keypad_time_entry_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1000,
  parameter int TMR_W          = 16
) (
  input  logic        ck,
  input  logic        rst_n,
  input  logic [7:0]  ps2_key_code,
  output logic [15:0] entry_bcd,
  output logic [2:0]  entry_count,
  output logic        load_time,
  output logic        load_alarm,
  output logic [15:0] time_bcd,
  output logic        entry_error,
  output logic        entry_timeout
);

  localparam logic [TMR_W-1:0] TMO_LAST = TMR_W'(TIMEOUT_CYCLES - 1);
  localparam logic [TMR_W-1:0] TMR_ONE  = TMR_W'(1);

  kp_state_e   state_q, state_d;
  logic [7:0]  key_q, key_d;
  logic [7:0]  prev_code_q;
  logic        armed_q;
  logic [TMR_W-1:0] timer_q, timer_d;
  logic [15:0] entry_bcd_q, entry_bcd_d;
  logic [2:0]  entry_count_q, entry_count_d;
  logic [15:0] time_bcd_q, time_bcd_d;
  logic        load_time_q, load_time_d;
  logic        load_alarm_q, load_alarm_d;
  logic        entry_error_q, entry_error_d;
  logic        entry_timeout_q, entry_timeout_d;

  logic        w_event;
  logic        w_in_is_digit, w_in_is_minus, w_in_is_star, w_in_is_release;
  logic [3:0]  w_in_digit;
  logic        w_in_make;
  logic        w_key_is_digit, w_key_is_minus, w_key_is_star, w_key_is_release;
  logic [3:0]  w_key_digit;
  logic        w_range_ok;
  logic [4:0]  w_unused_dec;

  kp_decode u_dec_in (
    .code_i       (ps2_key_code),
    .is_digit_o   (w_in_is_digit),
    .digit_o      (w_in_digit),
    .is_minus_o   (w_in_is_minus),
    .is_star_o    (w_in_is_star),
    .is_release_o (w_in_is_release)
  );

  kp_decode u_dec_key (
    .code_i       (key_q),
    .is_digit_o   (w_key_is_digit),
    .digit_o      (w_key_digit),
    .is_minus_o   (w_key_is_minus),
    .is_star_o    (w_key_is_star),
    .is_release_o (w_key_is_release)
  );

  assign w_unused_dec = {w_in_digit, w_key_is_release};
  assign w_in_make    = w_in_is_digit | w_in_is_minus | w_in_is_star;
  // armed_q suppresses the spurious event on the first cycle out of reset
  assign w_event      = armed_q && (ps2_key_code != prev_code_q);

`ifdef KEYPAD_TIME_ENTRY_RANGE_CHECK_EN
  assign w_range_ok = time_in_range(entry_bcd_q);
`else
  assign w_range_ok = 1'b1;
`endif

  always_comb begin
    state_d = state_q;
    key_d   = key_q;
    case (state_q)
      IDLE: begin
        if (w_event && w_in_make) begin
          state_d = MAKE;
          key_d   = ps2_key_code;
        end
      end
      MAKE: begin
        if (w_event) begin
          if (w_in_is_release) begin
            state_d = BREAK;
          end else if (w_in_make && (ps2_key_code != key_q)) begin
            key_d = ps2_key_code;
          end
        end
      end
      BREAK: begin
        if (w_event) begin
          if (ps2_key_code == key_q) begin
            state_d = ACCEPT;
          end else begin
            state_d = IDLE;
            key_d   = KP_INVALID;
          end
        end
      end
      ACCEPT:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    entry_bcd_d     = entry_bcd_q;
    entry_count_d   = entry_count_q;
    time_bcd_d      = time_bcd_q;
    load_time_d     = 1'b0;
    load_alarm_d    = 1'b0;
    entry_error_d   = 1'b0;
    entry_timeout_d = 1'b0;
    timer_d         = timer_q + TMR_ONE;
    // An accepted key outranks a timeout landing in the same cycle
    if (state_q == ACCEPT) begin
      timer_d = '0;
      if (w_key_is_digit) begin
        if (entry_count_q < 3'd4) begin
          entry_bcd_d   = {entry_bcd_q[11:0], w_key_digit};
          entry_count_d = entry_count_q + 3'd1;
        end
      end else if (w_key_is_minus || w_key_is_star) begin
        entry_bcd_d   = '0;
        entry_count_d = '0;
        if ((entry_count_q == 3'd4) && w_range_ok) begin
          time_bcd_d   = entry_bcd_q;
          load_time_d  = w_key_is_minus;
          load_alarm_d = w_key_is_star;
        end else begin
          entry_error_d = 1'b1;
        end
      end
    end else if (w_event || (entry_count_q == 3'd0)) begin
      timer_d = '0;
    end else if (timer_q == TMO_LAST) begin
      timer_d         = '0;
      entry_bcd_d     = '0;
      entry_count_d   = '0;
      entry_timeout_d = 1'b1;
    end
  end

  always_ff @(posedge ck or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= IDLE;
      key_q           <= KP_INVALID;
      prev_code_q     <= 8'h00;
      armed_q         <= 1'b0;
      timer_q         <= '0;
      entry_bcd_q     <= '0;
      entry_count_q   <= '0;
      time_bcd_q      <= '0;
      load_time_q     <= 1'b0;
      load_alarm_q    <= 1'b0;
      entry_error_q   <= 1'b0;
      entry_timeout_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      key_q           <= key_d;
      prev_code_q     <= ps2_key_code;
      armed_q         <= 1'b1;
      timer_q         <= timer_d;
      entry_bcd_q     <= entry_bcd_d;
      entry_count_q   <= entry_count_d;
      time_bcd_q      <= time_bcd_d;
      load_time_q     <= load_time_d;
      load_alarm_q    <= load_alarm_d;
      entry_error_q   <= entry_error_d;
      entry_timeout_q <= entry_timeout_d;
    end
  end

  assign entry_bcd     = entry_bcd_q;
  assign entry_count   = entry_count_q;
  assign time_bcd      = time_bcd_q;
  assign load_time     = load_time_q;
  assign load_alarm    = load_alarm_q;
  assign entry_error   = entry_error_q;
  assign entry_timeout = entry_timeout_q;

endmodule

`default_nettype wire

// File: tb/tb_keypad_time_entry.sv
// ============================================================================
// tb_keypad_time_entry : table, random and corner-case checks of keypad_time_entry
// Revision 1.0 : initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_keypad_time_entry;
  import keypad_time_entry_pkg::*;

  localparam int TMO = 64;
`ifdef KEYPAD_TIME_ENTRY_RANGE_CHECK_EN
  localparam bit RC = 1'b1;
`else
  localparam bit RC = 1'b0;
`endif

  logic        ck = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  ps2_key_code = KP_5;
  logic [15:0] entry_bcd, time_bcd;
  logic [2:0]  entry_count;
  logic        load_time, load_alarm, entry_error, entry_timeout;

  keypad_time_entry #(.TIMEOUT_CYCLES(TMO), .TMR_W(8)) dut (
    .ck            (ck),
    .rst_n         (rst_n),
    .ps2_key_code  (ps2_key_code),
    .entry_bcd     (entry_bcd),
    .entry_count   (entry_count),
    .load_time     (load_time),
    .load_alarm    (load_alarm),
    .time_bcd      (time_bcd),
    .entry_error   (entry_error),
    .entry_timeout (entry_timeout)
  );

  always #5 ck = ~ck;

  int checks = 0, errors = 0;
  int n_lt = 0, n_la = 0, n_err = 0, n_to = 0;

  always @(negedge ck) begin
    if (rst_n) begin
      if (load_time)     n_lt++;
      if (load_alarm)    n_la++;
      if (entry_error)   n_err++;
      if (entry_timeout) n_to++;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic settle(input int n);
    repeat (n) @(negedge ck);
    #1;
  endtask

  task automatic set_code(input logic [7:0] c, input int hold);
    @(negedge ck);
    ps2_key_code = c;
    repeat (hold - 1) @(negedge ck);
  endtask

  task automatic press(input logic [7:0] c, input int hold);
    set_code(c, hold);
    set_code(KP_KEY_RELEASED, hold);
    set_code(c, hold);
    set_code(KP_INVALID, hold);
  endtask

  function automatic logic [7:0] kp_code(input int k);
    case (k)
      0: return KP_0;   1: return KP_1;   2: return KP_2;   3: return KP_3;
      4: return KP_4;   5: return KP_5;   6: return KP_6;   7: return KP_7;
      8: return KP_8;   9: return KP_9;  10: return KP_MINUS;
      11: return KP_STAR;
      default: return KP_INVALID;
    endcase
  endfunction

  // Entry-level reference model: a queue of digits and cumulative strobe counts
  int          mq[$];
  logic [15:0] m_time;
  int          e_lt, e_la, e_err;

  function automatic logic [15:0] model_bcd();
    logic [15:0] v = 16'h0;
    foreach (mq[i]) v = v * 16 + 16'(mq[i]);
    return v;
  endfunction

  function automatic bit model_range_ok();
    int hours, mins;
    if (!RC) return 1'b1;
    hours = mq[0] * 10 + mq[1];
    mins  = mq[2] * 10 + mq[3];
    return (hours <= 23) && (mins <= 59);
  endfunction

  task automatic model_key(input int k);
    if (k < 10) begin
      if (mq.size() < 4) mq.push_back(k);
    end else begin
      if (mq.size() == 4 && model_range_ok()) begin
        if (k == 10) e_lt++; else e_la++;
        m_time = model_bcd();
      end else begin
        e_err++;
      end
      mq.delete();
    end
  endtask

  typedef struct {
    logic [19:0] digs;
    int          n;
    logic [7:0]  cmd;
    logic [2:0]  exp_cnt;
    logic [15:0] exp_bcd;
    logic        lt;
    logic        la;
    logic        err;
    logic [15:0] exp_time;
  } vec_t;

  vec_t tbl[10];

  initial begin
    int b_lt, b_la, b_err, b_to, k, k2, r, hold;
    logic [3:0] d;

    tbl[0] = '{20'h01234, 4, KP_MINUS, 3'd4, 16'h1234, 1'b1, 1'b0, 1'b0, 16'h1234};
    tbl[1] = '{20'h01235, 4, KP_STAR,  3'd4, 16'h1235, 1'b0, 1'b1, 1'b0, 16'h1235};
    tbl[2] = '{20'h02500, 4, KP_MINUS, 3'd4, 16'h2500, !RC, 1'b0, RC, RC ? 16'h1235 : 16'h2500};
    tbl[3] = '{20'h00012, 2, KP_STAR,  3'd2, 16'h0012, 1'b0, 1'b0, 1'b1, RC ? 16'h1235 : 16'h2500};
    tbl[4] = '{20'h23597, 5, KP_MINUS, 3'd4, 16'h2359, 1'b1, 1'b0, 1'b0, 16'h2359};
    tbl[5] = '{20'h00960, 4, KP_STAR,  3'd4, 16'h0960, 1'b0, !RC, RC, RC ? 16'h2359 : 16'h0960};
    tbl[6] = '{20'h01959, 4, KP_MINUS, 3'd4, 16'h1959, 1'b1, 1'b0, 1'b0, 16'h1959};
    tbl[7] = '{20'h00000, 0, KP_STAR,  3'd0, 16'h0000, 1'b0, 1'b0, 1'b1, 16'h1959};
    tbl[8] = '{20'h02400, 4, KP_STAR,  3'd4, 16'h2400, 1'b0, !RC, RC, RC ? 16'h1959 : 16'h2400};
    tbl[9] = '{20'h00123, 4, KP_MINUS, 3'd4, 16'h0123, 1'b1, 1'b0, 1'b0, 16'h0123};

    // Reset values while rst_n is held low
    repeat (3) @(negedge ck);
    #1;
    chk("rst_entry_bcd", entry_bcd, 0);
    chk("rst_entry_count", entry_count, 0);
    chk("rst_time_bcd", time_bcd, 0);
    chk("rst_load_time", load_time, 0);
    chk("rst_load_alarm", load_alarm, 0);
    chk("rst_entry_error", entry_error, 0);
    chk("rst_entry_timeout", entry_timeout, 0);

    // A code already held at reset release must not count as an event
    @(negedge ck) rst_n = 1'b1;
    settle(2);
    set_code(KP_KEY_RELEASED, 2);
    set_code(KP_5, 2);
    set_code(KP_INVALID, 2);
    settle(3);
    chk("first_cycle_no_event", entry_count, 0);
    set_code(KP_KEY_RELEASED, 2);
    set_code(KP_INVALID, 2);
    settle(3);

    // Table-driven entries
    for (int i = 0; i < 10; i++) begin
      b_lt = n_lt; b_la = n_la; b_err = n_err;
      for (int j = 0; j < tbl[i].n; j++) begin
        d = tbl[i].digs[4*(tbl[i].n-1-j) +: 4];
        press(kp_code(int'(d)), 3);
      end
      settle(2);
      chk($sformatf("tbl%0d_count", i), entry_count, tbl[i].exp_cnt);
      chk($sformatf("tbl%0d_bcd", i), entry_bcd, tbl[i].exp_bcd);
      press(tbl[i].cmd, 3);
      settle(3);
      chk($sformatf("tbl%0d_load_time", i), n_lt - b_lt, tbl[i].lt);
      chk($sformatf("tbl%0d_load_alarm", i), n_la - b_la, tbl[i].la);
      chk($sformatf("tbl%0d_error", i), n_err - b_err, tbl[i].err);
      chk($sformatf("tbl%0d_time_bcd", i), time_bcd, tbl[i].exp_time);
      chk($sformatf("tbl%0d_cleared", i), {entry_count, entry_bcd}, 0);
    end

    // Randomized key activity against the entry-level model
    m_time = 16'h0123;
    e_lt = n_lt; e_la = n_la; e_err = n_err;
    mq.delete();
    for (int it = 0; it < 200; it++) begin
      r    = $urandom_range(0, 99);
      hold = $urandom_range(1, 4);
      if (r < 65) begin
        k = $urandom_range(0, 9);
        press(kp_code(k), hold);
        model_key(k);
      end else if (r < 85) begin
        k = 10 + $urandom_range(0, 1);
        press(kp_code(k), hold);
        model_key(k);
      end else begin
        k  = $urandom_range(0, 11);
        k2 = (k + 1 + $urandom_range(0, 10)) % 12;
        if (r < 93) begin
          // release followed by a different key: press abandoned
          set_code(kp_code(k), hold);
          set_code(KP_KEY_RELEASED, hold);
          set_code(kp_code(k2), hold);
          set_code(KP_INVALID, hold);
        end else begin
          // rollover: second make replaces the first
          set_code(kp_code(k), hold);
          set_code(kp_code(k2), hold);
          set_code(KP_KEY_RELEASED, hold);
          set_code(kp_code(k2), hold);
          set_code(KP_INVALID, hold);
          model_key(k2);
        end
      end
      settle(3);
      chk("rnd_count", entry_count, mq.size());
      chk("rnd_bcd", entry_bcd, model_bcd());
      chk("rnd_load_time", n_lt, e_lt);
      chk("rnd_load_alarm", n_la, e_la);
      chk("rnd_error", n_err, e_err);
      chk("rnd_time_bcd", time_bcd, m_time);
    end
    press(KP_STAR, 3);
    settle(3);

    // Load latency: strobe two clocks after the matching release code
    b_lt = n_lt; b_la = n_la;
    press(KP_1, 5); press(KP_2, 5); press(KP_3, 5); press(KP_4, 5);
    set_code(KP_MINUS, 5);
    set_code(KP_KEY_RELEASED, 5);
    @(negedge ck) ps2_key_code = KP_MINUS;
    @(negedge ck) #1 chk("lat_early", load_time, 0);
    @(negedge ck) #1 chk("lat_strobe", load_time, 1);
    chk("lat_time_bcd", time_bcd, 16'h1234);
    @(negedge ck) #1 chk("lat_single", load_time, 0);
    ps2_key_code = KP_INVALID;
    settle(3);
    chk("lat_count", entry_count, 0);
    chk("lat_load_once", n_lt - b_lt, 1);
    chk("lat_no_alarm", n_la - b_la, 0);

    // Make 7, release, then 8: nothing accepted
    set_code(KP_7, 3);
    set_code(KP_KEY_RELEASED, 3);
    set_code(KP_8, 3);
    set_code(KP_INVALID, 3);
    settle(3);
    chk("mismatch_release_count", entry_count, 0);

    // Timeout of a partial entry
    b_lt = n_lt; b_la = n_la; b_to = n_to;
    set_code(KP_9, 5);
    set_code(KP_KEY_RELEASED, 5);
    set_code(KP_9, 5);
    @(negedge ck) ps2_key_code = KP_INVALID;
    k = 0;
    while (k < 4 * TMO) begin
      @(negedge ck);
      #1;
      k++;
      if (k == TMO) chk("tmo_count_before", entry_count, 1);
      if (entry_timeout) break;
    end
    chk("tmo_latency", k, TMO + 1);
    chk("tmo_cleared", {entry_count, entry_bcd}, 0);
    settle(3);
    chk("tmo_once", n_to - b_to, 1);
    chk("tmo_no_load", (n_lt - b_lt) + (n_la - b_la), 0);

    // Reset between release and the matching code of the third digit
    press(KP_1, 3); press(KP_2, 3);
    set_code(KP_3, 3);
    set_code(KP_KEY_RELEASED, 3);
    @(negedge ck);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_count", entry_count, 0);
    chk("arst_bcd", entry_bcd, 0);
    chk("arst_time_bcd", time_bcd, 0);
    repeat (2) @(negedge ck);
    rst_n = 1'b1;
    b_lt = n_lt; b_la = n_la; b_err = n_err;
    set_code(KP_3, 3);
    set_code(KP_INVALID, 3);
    settle(3);
    chk("arst_no_digit", entry_count, 0);
    chk("arst_no_strobe", (n_lt - b_lt) + (n_la - b_la) + (n_err - b_err), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
